// File: rtl/upfadder_pipe.sv
// Two-stage pipelined approximate adder: lower half built from K-bit blocks
// that a run-time config register enables or zeroes, upper half always exact.
module upfadder_pipe #(
  parameter int N = 32,
  parameter int K = 4,
  parameter logic [((N/2)/K)-1:0] CFG_RESET = '1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [((N/2)/K)-1:0]   cfg_i,
  input  logic                   cfg_we_i,
  output logic [((N/2)/K)-1:0]   cfg_o,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [N-1:0]           a_i,
  input  logic [N-1:0]           b_i,
  input  logic                   c_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [N-1:0]           s_o,
  output logic                   c_o,
  output logic                   exact_o
);

  localparam int H = N / 2;
  localparam int M = H / K;

  logic [M-1:0] cfg_q, cfg_d;

  logic         s1_valid_q, s1_valid_d;
  logic [H-1:0] s1_lo_q, s1_lo_d;
  logic         s1_cin_q, s1_cin_d;
  logic [H-1:0] s1_ahi_q, s1_ahi_d;
  logic [H-1:0] s1_bhi_q, s1_bhi_d;
  logic         s1_exact_q, s1_exact_d;

  logic         valid_q, valid_d;
  logic [N-1:0] s_q, s_d;
  logic         c_q, c_d;
  logic         exact_q, exact_d;

  logic         s2_adv;
  logic         accept;
  logic [H-1:0] lo_sum;
  logic         lo_carry;
  logic [K:0]   blk;
  logic [H:0]   hi_sum;

  assign s2_adv  = !valid_q || ready_i;
  assign ready_o = !s1_valid_q || s2_adv;
  assign accept  = valid_i && ready_o;

  assign cfg_o   = cfg_q;
  assign valid_o = valid_q;
  assign s_o     = s_q;
  assign c_o     = c_q;
  assign exact_o = exact_q;

  // A disabled block outputs zero and also kills the carry into the next block.
  always_comb begin
    lo_sum   = '0;
    lo_carry = c_i;
    blk      = '0;
    for (int unsigned j = 0; j < M; j++) begin
      if (cfg_q[j]) begin
        blk = {1'b0, a_i[K*j +: K]} + {1'b0, b_i[K*j +: K]} + {{K{1'b0}}, lo_carry};
        lo_sum[K*j +: K] = blk[K-1:0];
        lo_carry         = blk[K];
      end else begin
        lo_carry = 1'b0;
      end
    end
  end

  assign hi_sum = {1'b0, s1_ahi_q} + {1'b0, s1_bhi_q} + {{H{1'b0}}, s1_cin_q};

  always_comb begin
    cfg_d      = cfg_we_i ? cfg_i : cfg_q;

    s1_valid_d = s1_valid_q;
    s1_lo_d    = s1_lo_q;
    s1_cin_d   = s1_cin_q;
    s1_ahi_d   = s1_ahi_q;
    s1_bhi_d   = s1_bhi_q;
    s1_exact_d = s1_exact_q;
    if (ready_o) begin
      s1_valid_d = valid_i;
      if (accept) begin
        s1_lo_d    = lo_sum;
        s1_cin_d   = lo_carry;
        s1_ahi_d   = a_i[N-1:H];
        s1_bhi_d   = b_i[N-1:H];
        s1_exact_d = &cfg_q;
      end
    end

    valid_d = valid_q;
    s_d     = s_q;
    c_d     = c_q;
    exact_d = exact_q;
    if (s2_adv) begin
      valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s_d     = {hi_sum[H-1:0], s1_lo_q};
        c_d     = hi_sum[H];
        exact_d = s1_exact_q;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfg_q      <= CFG_RESET;
      s1_valid_q <= 1'b0;
      s1_lo_q    <= '0;
      s1_cin_q   <= 1'b0;
      s1_ahi_q   <= '0;
      s1_bhi_q   <= '0;
      s1_exact_q <= 1'b0;
      valid_q    <= 1'b0;
      s_q        <= '0;
      c_q        <= 1'b0;
      exact_q    <= 1'b0;
    end else begin
      cfg_q      <= cfg_d;
      s1_valid_q <= s1_valid_d;
      s1_lo_q    <= s1_lo_d;
      s1_cin_q   <= s1_cin_d;
      s1_ahi_q   <= s1_ahi_d;
      s1_bhi_q   <= s1_bhi_d;
      s1_exact_q <= s1_exact_d;
      valid_q    <= valid_d;
      s_q        <= s_d;
      c_q        <= c_d;
      exact_q    <= exact_d;
    end
  end

endmodule

// File: tb/tb_upfadder_pipe.sv
// Bench for upfadder_pipe: directed vectors with literal expectations plus a
// queue-based reference model checked on every cycle a result is presented.
module tb_upfadder_pipe;

  localparam int N = 32;
  localparam int K = 4;
  localparam int M = (N/2)/K;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic [M-1:0]  cfg_i;
  logic          cfg_we_i;
  logic [M-1:0]  cfg_o;
  logic          valid_i;
  logic          ready_o;
  logic [N-1:0]  a_i, b_i;
  logic          c_i;
  logic          valid_o;
  logic          ready_i;
  logic [N-1:0]  s_o;
  logic          c_o;
  logic          exact_o;

  upfadder_pipe #(.N(N), .K(K), .CFG_RESET(4'hF)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .cfg_i(cfg_i), .cfg_we_i(cfg_we_i),
    .cfg_o(cfg_o), .valid_i(valid_i), .ready_o(ready_o), .a_i(a_i),
    .b_i(b_i), .c_i(c_i), .valid_o(valid_o), .ready_i(ready_i),
    .s_o(s_o), .c_o(c_o), .exact_o(exact_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: {exact, carry out, sum}, block by block with plain integers.
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic c, input logic [3:0] cfg);
    longint unsigned lo, t, hi, carry;
    lo = 0;
    carry = c;
    for (int j = 0; j < M; j++) begin
      if (cfg[j]) begin
        t = ((a >> (4*j)) & 15) + ((b >> (4*j)) & 15) + carry;
        lo = lo | ((t & 15) << (4*j));
        carry = t >> 4;
      end else begin
        carry = 0;
      end
    end
    hi = longint'(a >> 16) + longint'(b >> 16) + carry;
    model = {&cfg, hi[16], hi[15:0], lo[15:0]};
  endfunction

  logic [33:0] exp_q[$];
  logic [M-1:0] cfg_m;
  logic        stalled = 1'b0;
  logic [33:0] held;
  logic        logging = 1'b0;
  logic        exact_log[$];

  always @(negedge clk) begin
    if (!rst_ni) begin
      exp_q.delete();
      cfg_m   = 4'hF;
      stalled = 1'b0;
    end else begin
      chk("cfg_o", 64'(cfg_o), 64'(cfg_m));
      if (valid_o) begin
        if (exp_q.size() == 0) begin
          chk("spurious_valid_o", 64'(valid_o), 64'd0);
        end else begin
          chk("result", 64'({exact_o, c_o, s_o}), 64'(exp_q[0]));
          if (stalled) chk("stall_stable", 64'({exact_o, c_o, s_o}), 64'(held));
          if (ready_i) begin
            void'(exp_q.pop_front());
            if (logging) exact_log.push_back(exact_o);
          end
        end
        stalled = !ready_i;
        held    = {exact_o, c_o, s_o};
      end else begin
        stalled = 1'b0;
      end
      if (valid_i && ready_o) exp_q.push_back(model(a_i, b_i, c_i, cfg_m));
      if (cfg_we_i) cfg_m = cfg_i;
    end
  end

  // Both tasks start and end at posedge+1.
  task automatic wr_cfg(input logic [3:0] v);
    cfg_i = v;
    cfg_we_i = 1'b1;
    @(posedge clk); #1;
    cfg_we_i = 1'b0;
    chk("cfg_write", 64'(cfg_o), 64'(v));
  endtask

  task automatic op(input string name, input logic [31:0] a, input logic [31:0] b,
                    input logic c, input logic [31:0] es, input logic ec, input logic ee);
    a_i = a; b_i = b; c_i = c;
    valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    @(negedge clk);
    chk({name, "_lat1"}, 64'(valid_o), 64'd0);
    @(negedge clk);
    chk({name, "_lat2"}, 64'(valid_o), 64'd1);
    chk({name, "_s"}, 64'(s_o), 64'(es));
    chk({name, "_c"}, 64'(c_o), 64'(ec));
    chk({name, "_exact"}, 64'(exact_o), 64'(ee));
    @(posedge clk); #1;
  endtask

  // Pins the model against hand-computed values.
  initial begin
    chk("model_exact", 64'(model(32'h0000FFFF, 32'h1, 1'b0, 4'hF)), 64'h2_0001_0000);
    chk("model_kill",  64'(model(32'h0000FFFF, 32'h1, 1'b0, 4'h7)), 64'h0_0000_0000);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [31:0] opa[8], opb[8];
  logic        opc[8];

  initial begin
    int idx, cyc, n;
    logic acc;
    rst_ni = 1'b0; ready_i = 1'b1; cfg_we_i = 1'b0; cfg_i = 4'h3;
    valid_i = 1'b1; a_i = $urandom; b_i = $urandom; c_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid_o", 64'(valid_o), 64'd0);
    chk("rst_cfg_o", 64'(cfg_o), 64'hF);
    chk("rst_s_o", 64'(s_o), 64'd0);
    chk("rst_c_exact", 64'({c_o, exact_o}), 64'd0);
    rst_ni = 1'b1; valid_i = 1'b0;
    #1;
    chk("ready_after_rst", 64'(ready_o), 64'd1);
    repeat (3) @(negedge clk) chk("idle_valid_o", 64'(valid_o), 64'd0);
    @(posedge clk); #1;

    wr_cfg(4'hF);
    op("exact", 32'h0000FFFF, 32'h1, 1'b0, 32'h00010000, 1'b0, 1'b1);
    wr_cfg(4'hE);
    op("zero_low", 32'h0000FFFF, 32'h1, 1'b0, 32'h0000FFF0, 1'b0, 1'b0);
    wr_cfg(4'h7);
    op("carry_kill", 32'h0000FFFF, 32'h1, 1'b0, 32'h00000000, 1'b0, 1'b0);
    wr_cfg(4'hF);
    op("upper_ovf", 32'hFFFF0000, 32'h00010000, 1'b0, 32'h00000000, 1'b1, 1'b1);

    // Stream with a 3-cycle stall; the config write coincides with the 4th acceptance.
    for (int i = 0; i < 8; i++) begin
      opa[i] = $urandom; opb[i] = $urandom; opc[i] = 1'($urandom_range(1));
    end
    logging = 1'b1;
    idx = 0; cyc = 0;
    while (idx < 8 && cyc < 100) begin
      ready_i = !(cyc >= 3 && cyc < 6);
      a_i = opa[idx]; b_i = opb[idx]; c_i = opc[idx];
      valid_i = 1'b1;
      #1;
      acc = ready_o;
      cfg_i = 4'h6;
      cfg_we_i = (idx == 3) && acc;
      @(posedge clk); #1;
      cfg_we_i = 1'b0;
      if (acc) idx++;
      cyc++;
    end
    valid_i = 1'b0; ready_i = 1'b1;
    chk("stream_issued", 64'(idx), 64'd8);
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk); n++;
    end
    #1;
    chk("stream_drained", 64'(exp_q.size()), 64'd0);
    chk("stream_count", 64'(exact_log.size()), 64'd8);
    for (int i = 0; i < 8 && i < exact_log.size(); i++)
      chk($sformatf("stream_cfg_op%0d", i + 1), 64'(exact_log[i]), (i < 4) ? 64'd1 : 64'd0);
    logging = 1'b0;

    // Asynchronous reset with a result held under backpressure.
    ready_i = 1'b0;
    a_i = 32'h12345678; b_i = 32'h11111111; c_i = 1'b0; valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_valid", 64'(valid_o), 64'd1);
    rst_ni = 1'b0;
    #1;
    chk("async_rst_valid", 64'(valid_o), 64'd0);
    chk("async_rst_s", 64'(s_o), 64'd0);
    chk("async_rst_cfg", 64'(cfg_o), 64'hF);
    @(posedge clk); #1;
    rst_ni = 1'b1; ready_i = 1'b1;
    repeat (3) @(negedge clk) chk("post_rst_idle", 64'(valid_o), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/upfadder_pipe.md
# upfadder_pipe

Two-stage pipelined, runtime-configurable approximate adder. It is the successor to the fixed-configuration split adder: the lower half is built from K-bit ripple blocks, each individually enabled or zeroed by a configuration register writable at run time, and the upper half is always exact. Operands and results move over valid/ready handshakes at one operation per cycle. It sits in the datapath wherever a fixed-parameter approximate adder was instantiated and per-workload accuracy control is needed.

## Interface
- N, 32, operand width; must be even.
- K, 4, approximate block width; N/2 must be a multiple of K. M = (N/2)/K blocks.
- CFG_RESET, all ones (M bits), configuration loaded at reset; bit j = 1 means block j is exact.
- clk_i  in  1  clock.
- rst_ni  in  1  reset; one clock, asynchronous, active-low.
- cfg_i  in  M  new approximation configuration.
- cfg_we_i  in  1  writes cfg_i into the configuration register.
- cfg_o  out  M  current configuration register contents.
- valid_i  in  1  operand valid.
- ready_o  out  1  block can accept operands.
- a_i  in  N  operand A.
- b_i  in  N  operand B.
- c_i  in  1  carry in.
- valid_o  out  1  result valid.
- ready_i  in  1  downstream accepts the result.
- s_o  out  N  sum.
- c_o  out  1  carry out of bit N-1.
- exact_o  out  1  result was computed with all M blocks enabled.

## Operation
- Block j covers bits [K*j+K-1 : K*j]. The carry chain is carry[0] = c_i.
- cfg[j] = 1: the block sum is the low K bits of a + b + carry[j], and carry[j+1] is the block carry out.
- cfg[j] = 0: the block's s_o bits are 0 and carry[j+1] = 0, whatever the inputs.
- The upper half s_o[N-1:N/2] is the exact sum a_i[N-1:N/2] + b_i[N-1:N/2] + carry[M]. Its carry out drives c_o.
- Stage 1 runs on acceptance (valid_i && ready_o). It computes the lower-half sum and carry[M], and registers them together with the upper operands and the exact flag.
- Stage 2 computes the upper half and registers s_o, c_o, exact_o and valid_o.
- Configuration is sampled per operation at acceptance. It travels with that operation and is never re-read later.
- A cfg_we_i write in the same cycle as an acceptance does not affect that operation; the operation uses the old value. The new value applies from the next accepted operation.
- Writes are allowed at any time and do not stall the pipeline.
- exact_o = AND of the sampled configuration bits.

## Timing
- Reset state: valid_o = 0, s_o = 0, c_o = 0, exact_o = 0, both stage valids = 0, cfg register = CFG_RESET. ready_o = 1 after reset is released.
- Latency: 2 cycles from acceptance to valid_o, with no backpressure.
- Throughput: 1 operation per cycle while ready_i = 1.
- Backpressure: each stage advances only if the next stage is empty or is advancing in the same cycle. ready_o = !s1_valid || (!valid_o || ready_i).
- This is combinational from ready_i. No skid buffer is required.
- While valid_o && !ready_i, s_o, c_o and exact_o hold stable.
- Accepting while full and draining in the same cycle is lossless.
- Reset asserted mid-operation discards all in-flight operations and restores the reset state immediately, asynchronously.
- cfg_o updates on the clock edge after a cfg_we_i cycle.

## Test plan
- Reset: drive rst_ni low with stimulus active. Required: valid_o = 0 and cfg_o = CFG_RESET. Release reset: ready_o = 1, and no valid_o until the first accepted operand.
- Exact mode: N=32, K=4, cfg = 4'b1111, a = 0x0000FFFF, b = 0x00000001, c_i = 0. Required: s_o = 0x00010000, c_o = 0, exact_o = 1, valid_o asserted 2 cycles after acceptance.
- Zeroed low block: same operands, cfg = 4'b1110. Required: s_o = 0x0000FFF0, exact_o = 0.
- Carry kill at the top of the lower half: same operands, cfg = 4'b0111. Required: s_o = 0x00000000.
- Upper overflow: cfg = 4'b1111, a = 0xFFFF0000, b = 0x00010000. Required: s_o = 0x00000000, c_o = 1.
- Backpressure and config race: stream 8 random operations back-to-back, hold ready_i low for 3 cycles mid-stream, and pulse cfg_we_i in the same cycle as the 4th acceptance. Required:
  - results are in order, with no loss or duplication;
  - outputs are stable while stalled;
  - operations 1–4 use the old configuration and 5–8 use the new one;
  - every result matches the reference model.
